// File: rtl/key_led_ctrl_if.sv
// Front-panel key/LED signal bundle: raw keys in, LED drive, press strobes and mode out.
interface key_led_ctrl_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] key;
  logic [N-1:0] led;
  logic [N-1:0] key_pulse;
  logic [1:0]   mode;

  modport master (output key, input led, input key_pulse, input mode);
  modport slave  (input key, output led, output key_pulse, output mode);
endinterface

// File: rtl/key_led_ctrl.sv
// Key-to-LED controller: per-key sync + debounce + press strobe, and a mode FSM
// that drives a bar-graph, running-water or all-off LED pattern (all active low).
module key_led_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned DEB_CYC  = 1000000,
  parameter int unsigned STEP_CYC = 25000000
) (
  input  logic           clk,
  input  logic           rst_n,
  key_led_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEB_CYC);
  localparam int unsigned SW = $clog2(STEP_CYC);
  localparam int unsigned LW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BAR  = 2'b01,
    RUN  = 2'b10
  } mode_e;

  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  stab_q, stab_d;
  logic [N-1:0]  stab_dly_q;
  logic [N-1:0]  pulse_q;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  mode_e         state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pos_q, pos_d;
  logic [SW-1:0] step_q, step_d;
  logic [N-1:0]  led_q, led_d;
  logic          hit;
  logic [LW-1:0] win;

  // Key path: two-flop synchroniser, debounced level, its delayed copy and the press strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '1;
      s2_q       <= '1;
      stab_q     <= '1;
      stab_dly_q <= '1;
      pulse_q    <= '0;
      cnt_q      <= '{default: '0};
    end else begin
      s1_q       <= bus.key;
      s2_q       <= s1_q;
      stab_q     <= stab_d;
      stab_dly_q <= stab_q;
      pulse_q    <= stab_dly_q & ~stab_q;
      cnt_q      <= cnt_d;
    end
  end

  // Any sample agreeing with the debounced level restarts that key's stability count.
  always_comb begin
    stab_d = stab_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYC - 1)) stab_d[i] = s2_q[i];
        else                              cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      pos_q   <= '0;
      step_q  <= '0;
      led_q   <= '1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      led_q   <= led_d;
    end
  end

  // Lowest-index strobe wins; a strobe always leaves RUN, so it pre-empts a pending step.
  always_comb begin
    hit     = 1'b0;
    win     = '0;
    state_d = state_q;
    level_d = level_q;
    pos_d   = pos_q;
    step_d  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pulse_q[i] && !hit) begin
        hit = 1'b1;
        win = LW'(i);
      end
    end
    if (hit) begin
      if (win != LW'(N - 1)) begin
        state_d = BAR;
        level_d = win;
      end else if (state_q == RUN) begin
        state_d = IDLE;
      end else begin
        state_d = RUN;
        pos_d   = '0;
      end
    end else if (state_q == RUN) begin
      if (step_q == SW'(STEP_CYC - 1)) pos_d = (pos_q == LW'(N - 1)) ? '0 : pos_q + 1'b1;
      else                             step_d = step_q + 1'b1;
    end
  end

  always_comb begin
    case (state_d)
      BAR:     led_d = ~((N'(2) << level_d) - N'(1));
      RUN:     led_d = ~(N'(1) << pos_d);
      default: led_d = '1;
    endcase
  end

  assign bus.led       = led_q;
  assign bus.key_pulse = pulse_q;
  assign bus.mode      = state_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl: directed front-panel scenarios plus random key activity,
// checked every cycle against a window-based behavioural model of the panel.
module tb_key_led_ctrl;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic clk;
  logic rst_n;

  key_led_ctrl_if #(.N(N)) bus ();

  key_led_ctrl #(
    .N       (N),
    .DEB_CYC (DEB),
    .STEP_CYC(STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %b required %b", name, $time, act, exp);
    end
  endtask

  // Behavioural model. Key levels reach the debouncer two edges late; a key's
  // debounced level flips once the last DEB delayed samples all disagree with it.
  bit           m_valid = 1'b0;
  logic [N-1:0] m_s1, m_s2, m_stab, m_old, m_fell, m_pulse, m_led;
  logic [N-1:0] m_win [DEB];
  int           m_mode, m_level, m_elapsed;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid   = 1'b1;
      m_s1      = '1;
      m_s2      = '1;
      m_stab    = '1;
      m_fell    = '0;
      m_pulse   = '0;
      for (int j = 0; j < DEB; j++) m_win[j] = '1;
      m_mode    = 0;
      m_level   = 0;
      m_elapsed = 0;
    end else begin
      int k;
      bit agree;
      k = -1;
      for (int i = 0; i < N; i++) if (m_pulse[i] && k < 0) k = i;
      if (m_mode == 2 && k < 0) m_elapsed++;
      if (k >= 0 && k < N - 1) begin
        m_mode  = 1;
        m_level = k;
      end else if (k == N - 1) begin
        if (m_mode == 2) m_mode = 0;
        else begin
          m_mode    = 2;
          m_elapsed = 0;
        end
      end
      m_pulse = m_fell;
      for (int j = DEB - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_s2;
      m_old = m_stab;
      for (int i = 0; i < N; i++) begin
        agree = 1'b1;
        for (int j = 0; j < DEB; j++) if (m_win[j][i] == m_stab[i]) agree = 1'b0;
        if (agree) m_stab[i] = ~m_stab[i];
      end
      m_fell = m_old & ~m_stab;
      m_s2   = m_s1;
      m_s1   = bus.key;
    end
    case (m_mode)
      1:       m_led = ~N'((2 << m_level) - 1);
      2:       m_led = ~N'(1 << ((m_elapsed / STEP) % N));
      default: m_led = '1;
    endcase
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("led",       8'(bus.led),       8'(m_led));
      check("key_pulse", 8'(bus.key_pulse), 8'(m_pulse));
      check("mode",      8'(bus.mode),      8'(m_mode));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hold;
    int sel;
    rst_n   = 1'b0;
    bus.key = '1;
    cyc(3);
    check("rst_led",   8'(bus.led),       8'b1111);
    check("rst_pulse", 8'(bus.key_pulse), 8'b0000);
    check("rst_mode",  8'(bus.mode),      8'b00);
    rst_n = 1'b1;
    cyc(50);
    check("idle_led",  8'(bus.led),  8'b1111);
    check("idle_mode", 8'(bus.mode), 8'b00);

    // Bar: key1 press
    bus.key = 4'b1101;
    cyc(7);
    check("bar_pulse", 8'(bus.key_pulse), 8'b0010);
    cyc(1);
    check("bar_pulse_gone", 8'(bus.key_pulse), 8'b0000);
    check("bar_led",  8'(bus.led),  8'b1100);
    check("bar_mode", 8'(bus.mode), 8'b01);
    bus.key = '1;
    cyc(20);
    check("bar_release_led", 8'(bus.led), 8'b1100);

    // Bounce on key0 never long enough to debounce
    repeat (5) begin
      bus.key = 4'b1110;
      cyc(3);
      bus.key = '1;
      cyc(2);
    end
    cyc(10);
    check("bounce_led",  8'(bus.led),  8'b1100);
    check("bounce_mode", 8'(bus.mode), 8'b01);
    bus.key = 4'b1110;
    cyc(10);
    check("bounce_hold_led", 8'(bus.led), 8'b1110);
    bus.key = '1;
    cyc(15);

    // Running water
    bus.key = 4'b0111;
    cyc(8);
    check("run_mode", 8'(bus.mode), 8'b10);
    check("run_led0", 8'(bus.led),  8'b1110);
    bus.key = '1;
    cyc(8);
    check("run_led1", 8'(bus.led), 8'b1101);
    cyc(8);
    check("run_led2", 8'(bus.led), 8'b1011);
    cyc(8);
    check("run_led3", 8'(bus.led), 8'b0111);
    cyc(8);
    check("run_wrap", 8'(bus.led), 8'b1110);
    bus.key = 4'b0111;
    cyc(8);
    check("run_stop_mode", 8'(bus.mode), 8'b00);
    check("run_stop_led",  8'(bus.led),  8'b1111);
    bus.key = '1;
    cyc(15);

    // Simultaneous presses of key0 and key2: key0 wins
    bus.key = 4'b1010;
    cyc(7);
    check("simul_pulse", 8'(bus.key_pulse), 8'b0101);
    cyc(1);
    check("simul_led",  8'(bus.led),  8'b1110);
    check("simul_mode", 8'(bus.mode), 8'b01);
    bus.key = '1;
    cyc(15);

    // Reset in the middle of RUN with key3 held through it
    bus.key = 4'b0111;
    cyc(8);
    check("mrst_run", 8'(bus.mode), 8'b10);
    bus.key = '1;
    cyc(21);
    check("mrst_pos2", 8'(bus.led), 8'b1011);
    bus.key = 4'b0111;
    rst_n   = 1'b0;
    cyc(1);
    check("mrst_led",   8'(bus.led),       8'b1111);
    check("mrst_mode",  8'(bus.mode),      8'b00);
    check("mrst_pulse", 8'(bus.key_pulse), 8'b0000);
    rst_n = 1'b1;
    cyc(6);
    check("mrst_no_early_pulse", 8'(bus.key_pulse), 8'b0000);
    cyc(1);
    check("mrst_fresh_pulse", 8'(bus.key_pulse), 8'b1000);
    cyc(1);
    check("mrst_rerun_mode", 8'(bus.mode), 8'b10);
    check("mrst_rerun_led",  8'(bus.led),  8'b1110);
    bus.key = '1;
    cyc(15);

    // Random key activity with occasional resets
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      sel = $urandom_range(0, 3);
      case (sel)
        0:       bus.key = '1;
        1:       bus.key = ~N'(1 << $urandom_range(0, N - 1));
        2:       bus.key = N'($urandom);
        default: bus.key = ~N'(1 << (N - 1));
      endcase
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 12);
      cyc(hold);
    end
    bus.key = '1;
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
